mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
- Parametrised successor to the single-cycle-handshake control unit of the multi-cycle RV64 core.
- Explicit Moore FSM sequences fetch, execute, memory and write-back per instruction.
- Decodes R, I-ALU, LD, SD, BRANCH, JAL, JALR and LUI; bounded memory-wait timeout; sticky error/finish.
- Sits between instruction/data memory handshakes and the datapath (ALU, register file, PC).

Parameters:
INST_W, 32, instruction width; opcode is i_inst[6:0]
HALT_OPC, 7'h7F, opcode that ends simulation
MEM_TIMEOUT, 16, max S_MWAIT cycles before error; 0 = wait forever
CNT_W, 32, performance counter width (used only with MC_CTRL_PERF_CNT_EN)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset, sampled on rising i_clk
i_inst  in  INST_W  instruction word; sampled only in S_IWAIT
i_inst_valid  in  1  instruction memory data valid
i_mem_valid  in  1  data memory read-data valid / write ack
o_inst_req  out  1  one-cycle instruction fetch request
o_mem_rd  out  1  one-cycle data read request
o_mem_wr  out  1  one-cycle data write request
o_alusrc  out  1  ALU B operand = immediate
o_aluop  out  2  00 add, 01 branch compare, 10 R funct, 11 I funct
o_wb_sel  out  2  00 ALU, 01 memory, 10 PC+4, 11 immediate
o_branch  out  1  conditional branch instruction
o_jump  out  1  JAL/JALR unconditional PC redirect
o_reg_we  out  1  one-cycle register file write enable
o_pc_we  out  1  one-cycle PC update enable
o_finish  out  1  sticky halt indication
o_err  out  1  sticky error (illegal opcode or memory timeout)
o_cyc_cnt, o_inst_cnt  out  CNT_W each  present only with MC_CTRL_PERF_CNT_EN

Behaviour:
- All outputs registered (Moore, from state plus opcode latched in S_IWAIT). Reset at posedge with i_rst_n=0: state=S_FETCH, all outputs 0, timeout counter 0; reset mid-instruction aborts it immediately.
- S_FETCH: o_inst_req=1 for exactly one cycle -> S_IWAIT.
- S_IWAIT: hold until i_inst_valid=1; latch opcode; HALT_OPC -> S_HALT; unsupported opcode -> S_HALT with o_err=1; else -> S_EXEC.
- S_EXEC: one cycle; levels o_alusrc/o_aluop/o_wb_sel/o_branch/o_jump driven from here to end of instruction, 0 in S_FETCH/S_IWAIT. LD/SD -> S_MEM; BRANCH -> S_PCUPD; others -> S_WB.
- Decode: R: aluop=10, wb=00. I-ALU: alusrc=1, aluop=11, wb=00. LD: alusrc=1, aluop=00, wb=01. SD: alusrc=1, aluop=00. BRANCH: aluop=01, branch=1. JAL/JALR: jump=1, wb=10, JALR alusrc=1, aluop=00. LUI: wb=11.
- S_MEM: o_mem_rd (LD) or o_mem_wr (SD) = 1 for one cycle -> S_MWAIT. i_mem_valid ignored here.
- S_MWAIT: i_mem_valid=1 -> S_WB (LD) or S_PCUPD (SD). Timeout counter increments each cycle waiting; reaching MEM_TIMEOUT without valid -> S_HALT, o_err=1. Counter clears on leaving S_MWAIT.
- S_WB: o_reg_we=1 and o_pc_we=1 for one cycle -> S_FETCH.
- S_PCUPD: o_pc_we=1 for one cycle (datapath selects target using o_branch and zero flag) -> S_FETCH.
- S_HALT: o_finish=1, all pulses 0, levels 0; stays until reset.
- Valid inputs outside their sampling state are ignored. Minimum latencies with 1-cycle memories: R/I/LUI/JAL/JALR/BRANCH 4 cycles, LD 6, SD 6.

Optional Feature:
- MC_CTRL_PERF_CNT_EN defined: o_cyc_cnt increments every non-reset cycle while not in S_HALT; o_inst_cnt increments on each o_pc_we; both wrap at 2^CNT_W and reset to 0.
- Not defined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset then inst_valid one cycle after o_inst_req with R opcode 7'h33 -> aluop=10, wb=00; o_reg_we and o_pc_we pulse in cycle 4; o_inst_req again in cycle 5.
- LD 7'h03, mem_valid 3 cycles after o_mem_rd -> single o_mem_rd pulse, wb=01, o_reg_we exactly once after valid, no o_mem_wr.
- SD 7'h23 with mem_valid withheld, MEM_TIMEOUT=16 -> o_err=1 and o_finish=1 after 16 wait cycles, o_reg_we never asserted.
- BRANCH 7'h63 then JAL 7'h6F -> branch=1, aluop=01, o_pc_we only, no reg_we; then jump=1, wb=10, reg_we=1.
- Opcode 7'h7F -> o_finish=1 sticky; opcode 7'h00 -> o_err=1; i_rst_n=0 during S_MWAIT -> next cycle all outputs 0, then o_inst_req.
- With MC_CTRL_PERF_CNT_EN, 3 R-type instructions -> o_inst_cnt=3, o_cyc_cnt=12 at third o_pc_we (1-cycle memories).

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV64 control unit: Moore FSM with registered outputs sequencing fetch/exec/mem/write-back.
// Define MC_CTRL_PERF_CNT_EN to add cycle and retired-instruction counters.
module mc_ctrl_fsm #(
    parameter int          INST_W      = 32,
    parameter logic [6:0]  HALT_OPC    = 7'h7F,
    parameter int          MEM_TIMEOUT = 16,
    parameter int          CNT_W       = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [INST_W-1:0] i_inst,
    input  logic              i_inst_valid,
    input  logic              i_mem_valid,
    output logic              o_inst_req,
    output logic              o_mem_rd,
    output logic              o_mem_wr,
    output logic              o_alusrc,
    output logic [1:0]        o_aluop,
    output logic [1:0]        o_wb_sel,
    output logic              o_branch,
    output logic              o_jump,
    output logic              o_reg_we,
    output logic              o_pc_we,
    output logic              o_finish,
`ifdef MC_CTRL_PERF_CNT_EN
    output logic [CNT_W-1:0]  o_cyc_cnt,
    output logic [CNT_W-1:0]  o_inst_cnt,
`endif
    output logic              o_err
);

    localparam logic [6:0] OPC_R      = 7'h33;
    localparam logic [6:0] OPC_I      = 7'h13;
    localparam logic [6:0] OPC_LD     = 7'h03;
    localparam logic [6:0] OPC_SD     = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_LUI    = 7'h37;

    localparam int              TO_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_FETCH, S_IWAIT, S_EXEC, S_MEM, S_MWAIT, S_WB, S_PCUPD, S_HALT
    } state_t;

    state_t          state_q, state_d;
    logic [6:0]      opc_q, opc_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            supported;
    logic            in_instr;

    logic            inst_req_d, mem_rd_d, mem_wr_d, alusrc_d, branch_d, jump_d;
    logic [1:0]      aluop_d, wb_sel_d;
    logic            reg_we_d, pc_we_d, finish_d, err_d;

    logic unused_inst_bits;
    assign unused_inst_bits = ^i_inst[INST_W-1:7];

    always_comb begin
        unique case (i_inst[6:0])
            OPC_R, OPC_I, OPC_LD, OPC_SD, OPC_BRANCH,
            OPC_JAL, OPC_JALR, OPC_LUI: supported = 1'b1;
            default:                    supported = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        opc_d    = opc_q;
        to_cnt_d = '0;
        err_d    = o_err;
        unique case (state_q)
            // Out of reset the request register is still low; stay one cycle to issue it.
            S_FETCH: if (o_inst_req) state_d = S_IWAIT;
            S_IWAIT: begin
                if (i_inst_valid) begin
                    opc_d = i_inst[6:0];
                    if (i_inst[6:0] == HALT_OPC) begin
                        state_d = S_HALT;
                    end else if (!supported) begin
                        state_d = S_HALT;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (opc_q == OPC_LD || opc_q == OPC_SD) state_d = S_MEM;
                else if (opc_q == OPC_BRANCH)          state_d = S_PCUPD;
                else                                   state_d = S_WB;
            end
            S_MEM:   state_d = S_MWAIT;
            S_MWAIT: begin
                if (i_mem_valid) begin
                    state_d = (opc_q == OPC_LD) ? S_WB : S_PCUPD;
                end else if (MEM_TIMEOUT != 0 && to_cnt_q == TO_LAST) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end else if (MEM_TIMEOUT != 0) begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_WB, S_PCUPD: state_d = S_FETCH;
            S_HALT:        state_d = S_HALT;
            default:       state_d = S_FETCH;
        endcase
    end

    // Outputs are decoded from the next state so each register lines up with its state.
    always_comb begin
        inst_req_d = (state_d == S_FETCH);
        mem_rd_d   = (state_d == S_MEM) && (opc_d == OPC_LD);
        mem_wr_d   = (state_d == S_MEM) && (opc_d == OPC_SD);
        reg_we_d   = (state_d == S_WB);
        pc_we_d    = (state_d == S_WB) || (state_d == S_PCUPD);
        finish_d   = (state_d == S_HALT);
        in_instr   = (state_d == S_EXEC) || (state_d == S_MEM) || (state_d == S_MWAIT) ||
                     (state_d == S_WB) || (state_d == S_PCUPD);
        alusrc_d   = 1'b0;
        aluop_d    = 2'b00;
        wb_sel_d   = 2'b00;
        branch_d   = 1'b0;
        jump_d     = 1'b0;
        if (in_instr) begin
            unique case (opc_d)
                OPC_R:      aluop_d = 2'b10;
                OPC_I:      begin alusrc_d = 1'b1; aluop_d = 2'b11; end
                OPC_LD:     begin alusrc_d = 1'b1; wb_sel_d = 2'b01; end
                OPC_SD:     alusrc_d = 1'b1;
                OPC_BRANCH: begin aluop_d = 2'b01; branch_d = 1'b1; end
                OPC_JAL:    begin jump_d = 1'b1; wb_sel_d = 2'b10; end
                OPC_JALR:   begin jump_d = 1'b1; wb_sel_d = 2'b10; alusrc_d = 1'b1; end
                OPC_LUI:    wb_sel_d = 2'b11;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= S_FETCH;
            opc_q      <= '0;
            to_cnt_q   <= '0;
            o_inst_req <= 1'b0;
            o_mem_rd   <= 1'b0;
            o_mem_wr   <= 1'b0;
            o_alusrc   <= 1'b0;
            o_aluop    <= 2'b00;
            o_wb_sel   <= 2'b00;
            o_branch   <= 1'b0;
            o_jump     <= 1'b0;
            o_reg_we   <= 1'b0;
            o_pc_we    <= 1'b0;
            o_finish   <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            state_q    <= state_d;
            opc_q      <= opc_d;
            to_cnt_q   <= to_cnt_d;
            o_inst_req <= inst_req_d;
            o_mem_rd   <= mem_rd_d;
            o_mem_wr   <= mem_wr_d;
            o_alusrc   <= alusrc_d;
            o_aluop    <= aluop_d;
            o_wb_sel   <= wb_sel_d;
            o_branch   <= branch_d;
            o_jump     <= jump_d;
            o_reg_we   <= reg_we_d;
            o_pc_we    <= pc_we_d;
            o_finish   <= finish_d;
            o_err      <= err_d;
        end
    end

`ifdef MC_CTRL_PERF_CNT_EN
    // Retired count tracks the PC-update register as it is loaded, so it matches o_pc_we's cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_cyc_cnt  <= '0;
            o_inst_cnt <= '0;
        end else begin
            if (state_q != S_HALT) o_cyc_cnt  <= o_cyc_cnt + CNT_W'(1);
            if (pc_we_d)           o_inst_cnt <= o_inst_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: per-cycle expected outputs built from instruction-level timing rules.
// Output vector order: inst_req, mem_rd, mem_wr, alusrc, aluop[1:0], wb_sel[1:0], branch, jump, reg_we, pc_we, finish, err.
module tb_mc_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst = '0;
    logic        inst_valid = 1'b0;
    logic        mem_valid = 1'b0;
    logic        inst_req, mem_rd, mem_wr, alusrc, branch, jump, reg_we, pc_we, finish, err;
    logic [1:0]  aluop, wb_sel;
`ifdef MC_CTRL_PERF_CNT_EN
    logic [31:0] cyc_cnt, inst_cnt;
`endif

    always #5 clk = ~clk;

    mc_ctrl_fsm dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_inst       (inst),
        .i_inst_valid (inst_valid),
        .i_mem_valid  (mem_valid),
        .o_inst_req   (inst_req),
        .o_mem_rd     (mem_rd),
        .o_mem_wr     (mem_wr),
        .o_alusrc     (alusrc),
        .o_aluop      (aluop),
        .o_wb_sel     (wb_sel),
        .o_branch     (branch),
        .o_jump       (jump),
        .o_reg_we     (reg_we),
        .o_pc_we      (pc_we),
        .o_finish     (finish),
`ifdef MC_CTRL_PERF_CNT_EN
        .o_cyc_cnt    (cyc_cnt),
        .o_inst_cnt   (inst_cnt),
`endif
        .o_err        (err)
    );

    typedef struct {
        logic        rst_n;
        logic        iv;
        logic        mv;
        logic        chk;
        logic [31:0] inst;
    } stim_t;

    stim_t       stim_q[$];
    logic [13:0] exp_q[$];
    int          pin_idx_q[$];
    logic [13:0] pin_val_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [6:0]  sup [8] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37};

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic is_sup(input logic [6:0] opc);
        foreach (sup[i]) if (sup[i] == opc) return 1'b1;
        return 1'b0;
    endfunction

    // {alusrc, aluop, wb_sel, branch, jump} held from execute to the end of the instruction
    function automatic logic [6:0] lv(input logic [6:0] opc);
        case (opc)
            7'h33:   return 7'b0_10_00_0_0;
            7'h13:   return 7'b1_11_00_0_0;
            7'h03:   return 7'b1_00_01_0_0;
            7'h23:   return 7'b1_00_00_0_0;
            7'h63:   return 7'b0_01_00_1_0;
            7'h6F:   return 7'b0_00_10_0_1;
            7'h67:   return 7'b1_00_10_0_1;
            7'h37:   return 7'b0_00_11_0_0;
            default: return 7'b0;
        endcase
    endfunction

    task automatic push(input logic r, input logic iv, input logic mv, input logic chk,
                        input logic [31:0] w, input logic [13:0] e);
        stim_t s;
        s.rst_n = r; s.iv = iv; s.mv = mv; s.chk = chk; s.inst = w;
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic pin(input int idx, input logic [13:0] v);
        pin_idx_q.push_back(idx);
        pin_val_q.push_back(v);
    endtask

    // lm: 1..16 = valid on that wait cycle, 0 = withheld (timeout), <0 = reset after -lm wait cycles.
    // kind: 0 normal, 1 halt opcode, 2 error, 3 aborted by reset.
    task automatic gen_inst(input logic [6:0] opc, input int li, input int lm,
                            output int start, output int kind);
        logic [31:0] w;
        logic [13:0] lvl;
        logic        mem_op;
        start = stim_q.size();
        kind  = 0;
        push(1, rb(), rb(), 1, $urandom, 14'h2000);
        for (int i = 1; i < li; i++) push(1, 0, rb(), 1, $urandom, 14'h0);
        w = $urandom;
        w[6:0] = opc;
        push(1, 1, rb(), 1, w, 14'h0);
        if (opc == 7'h7F) begin kind = 1; return; end
        if (!is_sup(opc)) begin kind = 2; return; end
        lvl = {3'b000, lv(opc), 4'b0000};
        push(1, rb(), rb(), 1, $urandom, lvl);
        mem_op = (opc == 7'h03) || (opc == 7'h23);
        if (mem_op) begin
            push(1, rb(), rb(), 1, $urandom, lvl | ((opc == 7'h03) ? 14'h1000 : 14'h0800));
            if (lm == 0) begin
                for (int i = 0; i < 16; i++) push(1, rb(), 0, 1, $urandom, lvl);
                kind = 2;
                return;
            end
            if (lm < 0) begin
                for (int i = 0; i < -lm; i++) push(1, rb(), 0, 1, $urandom, lvl);
                kind = 3;
                return;
            end
            for (int i = 1; i < lm; i++) push(1, rb(), 0, 1, $urandom, lvl);
            push(1, rb(), 1, 1, $urandom, lvl);
        end
        if (opc == 7'h23 || opc == 7'h63) push(1, rb(), rb(), 1, $urandom, lvl | 14'h0004);
        else                              push(1, rb(), rb(), 1, $urandom, lvl | 14'h000C);
    endtask

    task automatic gen_halt(input logic e, input int n);
        for (int i = 0; i < n; i++) push(1, rb(), rb(), 1, $urandom, {12'b0, 1'b1, e});
    endtask

    task automatic gen_reset();
        push(0, rb(), rb(), 0, $urandom, 14'h0);
        push(1, rb(), rb(), 1, $urandom, 14'h0);
    endtask

    task automatic settle(input int kind);
        if (kind == 1) gen_halt(0, $urandom_range(1, 3));
        if (kind == 2) gen_halt(1, $urandom_range(1, 3));
        if (kind != 0) gen_reset();
    endtask

    task automatic build();
        int s, k, li, lm;
        logic [6:0] opc;
        gen_reset();
        gen_inst(7'h33, 1, 1, s, k);
        pin(s + 2, 14'h0200);
        pin(s + 3, 14'h020C);
        pin(s + 4, 14'h2000);
        gen_inst(7'h33, 1, 1, s, k);
        gen_inst(7'h33, 1, 1, s, k);
        gen_inst(7'h03, 1, 3, s, k);
        pin(s + 3, 14'h1440);
        pin(s + 7, 14'h044C);
        gen_inst(7'h63, 2, 1, s, k);
        pin(s + 3, 14'h0120);
        pin(s + 4, 14'h0124);
        gen_inst(7'h6F, 1, 1, s, k);
        pin(s + 3, 14'h009C);
        gen_inst(7'h23, 1, 0, s, k);
        pin(s + 20, 14'h0003);
        settle(k);
        gen_inst(7'h7F, 1, 1, s, k);
        pin(s + 2, 14'h0002);
        settle(k);
        gen_inst(7'h00, 1, 1, s, k);
        pin(s + 2, 14'h0003);
        settle(k);
        gen_inst(7'h03, 2, -3, s, k);
        settle(k);
        pin(stim_q.size() - 1, 14'h0000);
        gen_inst(7'h13, 1, 1, s, k);
        pin(s, 14'h2000);
        gen_inst(7'h03, 1, 16, s, k);
        gen_inst(7'h23, 3, 16, s, k);
        gen_inst(7'h67, 1, 1, s, k);
        gen_inst(7'h37, 1, 1, s, k);
        for (int n = 0; n < 200; n++) begin
            int r;
            r  = $urandom_range(0, 31);
            li = $urandom_range(1, 4);
            lm = $urandom_range(1, 16);
            if (r < 24) begin
                opc = sup[r % 8];
            end else if (r < 26) begin
                opc = 7'h7F;
            end else if (r < 28) begin
                do opc = 7'($urandom); while (is_sup(opc) || opc == 7'h7F);
            end else begin
                opc = (r[0]) ? 7'h03 : 7'h23;
                lm  = (r < 30) ? 0 : -int'($urandom_range(1, 15));
            end
            gen_inst(opc, li, lm, s, k);
            settle(k);
        end
    endtask

    initial begin
        logic [13:0] act;
        int          pp;
`ifdef MC_CTRL_PERF_CNT_EN
        int          exp_cyc = 0;
        int          exp_ins = 0;
`endif
        pp = 0;
        build();
        for (int k = 0; k < stim_q.size(); k++) begin
            @(posedge clk);
            #1;
            rst_n      = stim_q[k].rst_n;
            inst_valid = stim_q[k].iv;
            mem_valid  = stim_q[k].mv;
            inst       = stim_q[k].inst;
            @(negedge clk);
            act = {inst_req, mem_rd, mem_wr, alusrc, aluop, wb_sel, branch, jump,
                   reg_we, pc_we, finish, err};
            if (stim_q[k].chk) begin
                tests++;
                if (act !== exp_q[k]) begin
                    fails++;
                    $display("FAIL outputs cycle %0d: got %h expected %h", k, act, exp_q[k]);
                end
            end
            while (pp < pin_idx_q.size() && pin_idx_q[pp] == k) begin
                tests++;
                if (act !== pin_val_q[pp]) begin
                    fails++;
                    $display("FAIL pin cycle %0d: got %h expected %h", k, act, pin_val_q[pp]);
                end
                pp++;
            end
`ifdef MC_CTRL_PERF_CNT_EN
            if (k > 0) begin
                exp_cyc = (!stim_q[k-1].rst_n) ? 0 : exp_cyc + (exp_q[k-1][1] ? 0 : 1);
                exp_ins = (!stim_q[k-1].rst_n) ? 0 : exp_ins + int'(exp_q[k][2]);
                if (stim_q[k].chk) begin
                    tests++;
                    if (cyc_cnt !== 32'(exp_cyc) || inst_cnt !== 32'(exp_ins)) begin
                        fails++;
                        $display("FAIL perf cycle %0d: got cyc=%0d inst=%0d expected cyc=%0d inst=%0d",
                                 k, cyc_cnt, inst_cnt, exp_cyc, exp_ins);
                    end
                end
            end
            if (k == 13) begin
                tests++;
                if (cyc_cnt !== 32'd12 || inst_cnt !== 32'd3) begin
                    fails++;
                    $display("FAIL perf_three_r: got cyc=%0d inst=%0d expected cyc=12 inst=3",
                             cyc_cnt, inst_cnt);
                end
            end
`endif
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
